// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce/synchronizer channels.
package debounce_pkg;

  // Per-channel debouncer states; encoding is fixed so it can be probed on
  // a logic analyser and matched against the documented values.
  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_RISE_WAIT = 2'd1,
    ST_HIGH      = 2'd2,
    ST_FALL_WAIT = 2'd3
  } state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

  // Counter width needed to hold 0..cycles-1, never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles <= 1) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input bit: 2-flop synchronizer followed by a counting debouncer that
// emits a registered level and single-cycle rise/fall pulses.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s0_reg;
  logic             s1_reg;
  logic             ds;
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             q_reg, q_next;
  logic             rise_reg, rise_next;
  logic             fall_reg, fall_next;

  assign ds = s1_reg;

  // Two-stage synchronizer for the raw asynchronous pin.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_reg <= 1'b0;
      s1_reg <= 1'b0;
    end else begin
      s0_reg <= din;
      s1_reg <= s0_reg;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_LOW;
      count_reg <= '0;
      q_reg     <= 1'b0;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      q_reg     <= q_next;
      rise_reg  <= rise_next;
      fall_reg  <= fall_next;
    end
  end

  // Next-state logic: a change is accepted only after the synchronized input
  // has held the new value on DEBOUNCE_CYCLES+1 consecutive edges.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    q_next     = q_reg;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    case (state_reg)
      ST_LOW: begin
        if (ds) begin
          state_next = ST_RISE_WAIT;
          count_next = '0;
        end
      end
      ST_RISE_WAIT: begin
        if (!ds) begin
          state_next = ST_LOW;
          count_next = '0;
        end else if (count_reg == CNT_LAST) begin
          state_next = ST_HIGH;
          count_next = '0;
          q_next     = 1'b1;
          rise_next  = 1'b1;
        end else begin
          count_next = count_reg + CNT_W'(1);
        end
      end
      ST_HIGH: begin
        if (!ds) begin
          state_next = ST_FALL_WAIT;
          count_next = '0;
        end
      end
      ST_FALL_WAIT: begin
        if (ds) begin
          state_next = ST_HIGH;
          count_next = '0;
        end else if (count_reg == CNT_LAST) begin
          state_next = ST_LOW;
          count_next = '0;
          q_next     = 1'b0;
          fall_next  = 1'b1;
        end else begin
          count_next = count_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = ST_LOW;
        count_next = '0;
        q_next     = 1'b0;
      end
    endcase
  end

  assign q    = q_reg;
  assign rise = rise_reg;
  assign fall = fall_reg;

endmodule

// File: rtl/debounce_sync.sv
// Bank of independent synchronize-and-debounce channels.
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int N_CH            = 1,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] din,
  output logic [N_CH-1:0] q,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall
);

  // One self-contained conditioner per input bit.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (din[gi]),
      .q    (q[gi]),
      .rise (rise[gi]),
      .fall (fall[gi])
    );
  end

endmodule

// File: tb/tb_debounce_sync.sv
// Scoreboard bench for debounce_sync: directed scenarios plus random stimulus
// against a run-length reference model.
module tb_debounce_sync;

  localparam int N = 4;
  localparam int D = 4;

  typedef struct packed {
    logic [N-1:0] q;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] din = '0;
  logic [N-1:0] q, rise, fall;

  debounce_sync #(.N_CH(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (din),
    .q    (q),
    .rise (rise),
    .fall (fall)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   edge_cnt = 0;
  exp_t exp_q[$];

  // Observations of DUT pulses, compared against directed expectations.
  int           rise_cnt = 0, fall_cnt = 0;
  int           last_rise_edge = -1, last_fall_edge = -1;
  logic [N-1:0] last_rise_vec = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a channel's synchronized value is the pin delayed two
  // edges; the level flips once that value has differed from the level for
  // D+1 consecutive edges. Tracked as run lengths of equal samples.
  logic [N-1:0] m_d1 = '0, m_d2 = '0, m_q = '0, m_last = '0;
  int           m_run [N];

  task automatic model_step();
    exp_t e;
    logic ds;
    e = '0;
    if (!rst_n) begin
      m_d1 = '0; m_d2 = '0; m_q = '0; m_last = '0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        ds = m_d2[i];
        if (ds == m_last[i]) begin
          if (m_run[i] < 1000) m_run[i]++;
        end else begin
          m_last[i] = ds;
          m_run[i]  = 1;
        end
        if (ds != m_q[i] && m_run[i] >= D + 1) begin
          m_q[i] = ds;
          if (ds) e.rise[i] = 1'b1;
          else    e.fall[i] = 1'b1;
        end
      end
      m_d2 = m_d1;
      m_d1 = din;
    end
    e.q = m_q;
    exp_q.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      edge_cnt++;
      model_step();
    end
  end

  // Monitor: every cycle is an output beat; pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({q, rise, fall} !== e) begin
          n_fail++;
          $display("FAIL cycle_out edge %0d: got q=%b rise=%b fall=%b, expected q=%b rise=%b fall=%b",
                   edge_cnt, q, rise, fall, e.q, e.rise, e.fall);
        end
      end
      if (rise != '0) begin
        rise_cnt++;
        last_rise_edge = edge_cnt;
        last_rise_vec  = rise;
        $display("edge %0d: rise=%b q=%b", edge_cnt, rise, q);
      end
      if (fall != '0) begin
        fall_cnt++;
        last_fall_edge = edge_cnt;
        $display("edge %0d: fall=%b q=%b", edge_cnt, fall, q);
      end
    end
  end

  // Advance n cycles; land just after a falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clr();
    rise_cnt = 0; fall_cnt = 0;
    last_rise_edge = -1; last_fall_edge = -1; last_rise_vec = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", edge_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int hold;
    rst_n = 1'b0;
    din   = '0;
    cyc(3);
    rst_n = 1'b1;
    check("reset_q", 32'(q), 32'(0));
    check("reset_pulses", 32'({rise, fall}), 32'(0));
    cyc(3);

    // Clean rise on channel 0.
    clr();
    din = 4'b0001; k = edge_cnt + 1;
    cyc(10);
    check("clean_rise_edge", 32'(last_rise_edge), 32'(k + 6));
    check("clean_rise_count", 32'(rise_cnt), 32'(1));
    check("clean_rise_nofall", 32'(fall_cnt), 32'(0));
    check("clean_rise_q", 32'(q), 32'(4'b0001));

    // Clean fall on channel 0.
    clr();
    din = 4'b0000; k = edge_cnt + 1;
    cyc(10);
    check("clean_fall_edge", 32'(last_fall_edge), 32'(k + 6));
    check("clean_fall_count", 32'(fall_cnt), 32'(1));
    check("clean_fall_norise", 32'(rise_cnt), 32'(0));

    // Glitch of exactly D cycles is rejected.
    clr();
    din = 4'b0001; cyc(D);
    din = 4'b0000; cyc(12);
    check("glitch4_rise", 32'(rise_cnt), 32'(0));
    check("glitch4_fall", 32'(fall_cnt), 32'(0));
    check("glitch4_q", 32'(q), 32'(0));

    // Pulse of D+1 cycles is accepted.
    clr();
    din = 4'b0001; cyc(D + 1);
    din = 4'b0000; cyc(2);
    check("pulse5_rise", 32'(rise_cnt), 32'(1));
    cyc(12);
    check("pulse5_fall", 32'(fall_cnt), 32'(1));

    // Bounce 1,0,1,1,0,1 then steady 1.
    clr();
    din = 4'b0001; cyc(1);
    din = 4'b0000; cyc(1);
    din = 4'b0001; cyc(2);
    din = 4'b0000; cyc(1);
    din = 4'b0001; k = edge_cnt + 1;
    cyc(14);
    check("bounce_count", 32'(rise_cnt), 32'(1));
    check("bounce_edge", 32'(last_rise_edge), 32'(k + 6));
    din = 4'b0000; cyc(12);

    // Reset while waiting with count==2 discards progress.
    clr();
    din = 4'b0001; k = edge_cnt + 1;
    cyc(5);
    rst_n = 1'b0; cyc(1);
    rst_n = 1'b1;
    check("midreset_q", 32'(q), 32'(0));
    check("midreset_nopulse", 32'(rise_cnt), 32'(0));
    cyc(10);
    check("midreset_edge", 32'(last_rise_edge), 32'(k + 12));
    check("midreset_count", 32'(rise_cnt), 32'(1));
    din = 4'b0000; cyc(12);

    // Simultaneous rises on several channels.
    clr();
    din = 4'b1010; cyc(10);
    check("multi_rise_vec", 32'(last_rise_vec), 32'(4'b1010));
    check("multi_rise_count", 32'(rise_cnt), 32'(1));
    check("multi_q", 32'(q), 32'(4'b1010));
    clr();
    din = 4'b1000; cyc(2);
    din = 4'b1010; cyc(10);
    check("multi_glitch_fall", 32'(fall_cnt), 32'(0));
    check("multi_glitch_q", 32'(q), 32'(4'b1010));

    // Random segments with occasional resets; the scoreboard checks every cycle.
    for (int it = 0; it < 1200; it++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0; cyc(1);
        rst_n = 1'b1;
      end
      din  = N'($urandom);
      hold = $urandom_range(1, D + 3);
      cyc(hold);
    end
    cyc(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
